// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the minicpu instruction-fetch controller:
// word width and the 3-bit controller state encodings.
package fetch_ctrl_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ST_W   = 3;

    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_ISSUE  = 3'd1;
    localparam logic [ST_W-1:0] ST_DATA   = 3'd2;
    localparam logic [ST_W-1:0] ST_HOLD   = 3'd3;
    localparam logic [ST_W-1:0] ST_HALTED = 3'd4;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives pc inc/load, reads the synchronous ROM at
// the PC and presents each instruction to the decoder over valid/ready.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_addr,
    output logic [WIDTH-1:0] pc_in,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             jump_req,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             halt,
    output logic             halted
);

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  state_nx;
    logic [WIDTH-1:0] issued_addr;
    logic             jump_take;
    logic             issue_ld;
    logic             instr_ld;

    assign rom_addr  = pc_addr;
    assign pc_in     = jump_target;
    assign jump_take = jump_req && (state != ST_IDLE);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and PC control; a jump overrides everything and drops any fetch
    always_comb begin
        state_nx = state;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        issue_ld = 1'b0;
        instr_ld = 1'b0;

        case (state)
            ST_IDLE: begin
                state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                pc_inc   = 1'b1;
                issue_ld = 1'b1;
                state_nx = ST_DATA;
            end
            ST_DATA: begin
                instr_ld = 1'b1;
                state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    state_nx = halt ? ST_HALTED : ST_ISSUE;
                end
            end
            ST_HALTED: begin
                state_nx = ST_HALTED;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        if (jump_take) begin
            pc_load  = 1'b1;
            pc_inc   = 1'b0;
            issue_ld = 1'b0;
            instr_ld = 1'b0;
            state_nx = ST_ISSUE;
        end

        if (reset) begin
            pc_inc  = 1'b0;
            pc_load = 1'b0;
        end
    end

    // Fetch datapath and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            issued_addr <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            if (issue_ld) begin
                issued_addr <= pc_addr;
            end
            if (instr_ld) begin
                instr    <= rom_data;
                instr_pc <= issued_addr;
            end
            instr_valid <= (state_nx == ST_HOLD);
            halted      <= (state_nx == ST_HALTED);
        end
    end

endmodule
